// File: rtl/writeback_stage_pkg.sv
// -----------------------------------------------------------------------------
// writeback_stage_pkg
//   Shared RV32 writeback definitions: datapath width, result-source select
//   codes, load funct3 encodings, the FSM state type and the commit record that
//   travels from the result mux to the register-file write port.
//   Used by writeback_stage and load_extend.
// -----------------------------------------------------------------------------
package writeback_stage_pkg;

   localparam int XLEN = 32;

   // Result source select (in_wb_sel); code 3 is reserved and behaves as ALU.
   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_PC4  = 2'd2;

   // Load size/sign encodings (funct3).
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      WB_IDLE      = 1'b0,
      WB_WAIT_LOAD = 1'b1
   } wb_state_t;

   // One register-file write candidate.
   typedef struct packed {
      logic [4:0]      rd;
      logic            regwrite;
      logic [XLEN-1:0] data;
   } wb_commit_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
//   Combinational load-data alignment: selects the byte/halfword lane addressed
//   by the low address bits of a raw aligned word and sign- or zero-extends it.
//   Ports:
//     funct3  in  3     load type (LB/LH/LW/LBU/LHU; other codes act as LW)
//     offset  in  2     byte offset within the word (bit 0 ignored for halfwords)
//     raw     in  XLEN  aligned word returned by data memory
//     result  out XLEN  extended load value
// -----------------------------------------------------------------------------
module load_extend
   import writeback_stage_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] result
);

   logic signed [7:0]  byte_lane;
   logic signed [15:0] half_lane;

   always_comb begin
      byte_lane = '0;
      case (offset)
         2'd0:    byte_lane = raw[7:0];
         2'd1:    byte_lane = raw[15:8];
         2'd2:    byte_lane = raw[23:16];
         default: byte_lane = raw[31:24];
      endcase
      half_lane = offset[1] ? raw[31:16] : raw[15:0];
   end

   always_comb begin
      result = raw;
      case (funct3)
         F3_LB:   result = XLEN'(byte_lane);                     // signed cast sign-extends
         F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_lane};
         F3_LH:   result = XLEN'(half_lane);
         F3_LHU:  result = {{(XLEN-16){1'b0}}, half_lane};
         default: result = raw;                                  // LW and unused codes
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   Final RV32 pipeline stage. Accepts retiring instructions from the memory
//   stage, waits for data-memory load responses, aligns/extends load data,
//   selects the result source and drives the register-file write port with a
//   one-cycle RegWrite pulse per write.
//
//   Optional feature: define WB_RETIRE_CNT_EN to build the retired-instruction
//   counter on instret; otherwise instret is tied to zero.
//
//   Ports:
//     clock, reset      rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready handshake with the memory stage
//     in_rd, in_regwrite, in_wb_sel, in_funct3, in_alu_result, in_pc_plus4
//                       instruction fields (alu_result[1:0] = load offset)
//     dmem_rvalid/dmem_rdata  in-order load response
//     flush             kill the load held in this stage
//     Write_register, Write_data, RegWrite   register-file write port
//     retired           one-cycle pulse per committed instruction
//     instret           retired count (WB_RETIRE_CNT_EN only)
// -----------------------------------------------------------------------------
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int CNT_W = 64
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rd,
   input  logic             in_regwrite,
   input  logic [1:0]       in_wb_sel,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_alu_result,
   input  logic [XLEN-1:0]  in_pc_plus4,
   input  logic             dmem_rvalid,
   input  logic [XLEN-1:0]  dmem_rdata,
   input  logic             flush,
   output logic [4:0]       Write_register,
   output logic [XLEN-1:0]  Write_data,
   output logic             RegWrite,
   output logic             retired,
   output logic [CNT_W-1:0] instret
);

   wb_state_t state, state_nxt;
   logic      drop_pending, drop_pending_nxt;

   logic      is_load;
   logic      accept;
   logic      load_done;

   // Latched fields of the outstanding load.
   logic [4:0] ld_rd_p0;
   logic       ld_regwrite_p0;
   logic [2:0] ld_funct3_p0;
   logic [1:0] ld_off_p0;

   logic [XLEN-1:0] load_data;
   wb_commit_t      new_entry, load_entry, commit_entry;
   logic            new_vld, commit_vld;

   // A non-load accepted in the same cycle a load completes cannot share the
   // load's commit edge, so it waits one cycle here. Later back-to-back ops
   // keep flowing through this slot, preserving order at one commit per edge.
   wb_commit_t pend_p0;
   logic       pend_vld_p0;

   assign is_load = (in_wb_sel == WB_SEL_LOAD);

   // ---- FSM: state register ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= WB_IDLE;
         drop_pending <= 1'b0;
      end else begin
         state        <= state_nxt;
         drop_pending <= drop_pending_nxt;
      end
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt        = state;
      drop_pending_nxt = drop_pending;
      case (state)
         WB_IDLE: begin
            // The response of a flushed load is swallowed here.
            if (drop_pending && dmem_rvalid)
               drop_pending_nxt = 1'b0;
            if (accept && is_load)
               state_nxt = WB_WAIT_LOAD;
         end
         WB_WAIT_LOAD: begin
            if (flush) begin
               state_nxt        = WB_IDLE;
               drop_pending_nxt = !dmem_rvalid;
            end else if (dmem_rvalid) begin
               state_nxt = (accept && is_load) ? WB_WAIT_LOAD : WB_IDLE;
            end
         end
         default: state_nxt = WB_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      in_ready  = !drop_pending &&
                  ((state == WB_IDLE) || ((state == WB_WAIT_LOAD) && dmem_rvalid));
      accept    = in_valid && in_ready && !flush;
      load_done = (state == WB_WAIT_LOAD) && dmem_rvalid && !flush;
   end

   always_ff @(posedge clock) begin
      if (accept && is_load) begin
         ld_rd_p0       <= in_rd;
         ld_regwrite_p0 <= in_regwrite;
         ld_funct3_p0   <= in_funct3;
         ld_off_p0      <= in_alu_result[1:0];
      end
   end

   load_extend u_load_extend (
      .funct3 (ld_funct3_p0),
      .offset (ld_off_p0),
      .raw    (dmem_rdata),
      .result (load_data)
   );

   always_comb begin
      new_vld            = accept && !is_load;
      new_entry.rd       = in_rd;
      new_entry.regwrite = in_regwrite;
      new_entry.data     = (in_wb_sel == WB_SEL_PC4) ? in_pc_plus4 : in_alu_result;

      load_entry.rd       = ld_rd_p0;
      load_entry.regwrite = ld_regwrite_p0;
      load_entry.data     = load_data;

      // Oldest first: held op, then completing load, then newly accepted op.
      commit_vld   = pend_vld_p0 || load_done || new_vld;
      commit_entry = pend_vld_p0 ? pend_p0 : (load_done ? load_entry : new_entry);
   end

   // ---- stage boundary: holding slot ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         pend_vld_p0 <= 1'b0;
      else
         pend_vld_p0 <= (pend_vld_p0 || load_done) && new_vld;
   end

   always_ff @(posedge clock) begin
      pend_p0 <= new_entry;
   end

   // ---- stage boundary: register-file write port ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         Write_register <= '0;
         Write_data     <= '0;
         RegWrite       <= 1'b0;
         retired        <= 1'b0;
      end else begin
         retired  <= commit_vld;
         // x0 is hard-wired; the write is still reported as retired.
         RegWrite <= commit_vld && commit_entry.regwrite && (commit_entry.rd != 5'd0);
         if (commit_vld) begin
            Write_register <= commit_entry.rd;
            Write_data     <= commit_entry.data;
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] instret_cnt;

   // Counts alongside the retired pulse, so instret includes the current one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         instret_cnt <= '0;
      else if (commit_vld)
         instret_cnt <= instret_cnt + CNT_W'(1);
   end

   assign instret = instret_cnt;
`else
   assign instret = '0;
`endif

endmodule
